mem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU datapath and the byte-addressed, big-endian data memory (`dataMem`). It accepts one load or store request at a time over a valid/ready handshake and drives the memory's `address`, `writedata` and `writeenable` ports. Sub-word stores are performed as a read-modify-write of the enclosing word. It returns load data (sign- or zero-extended) and an error flag as a single-cycle response pulse.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Big-endian load/store initiator for dataMem; sub-word stores are done as read-modify-write.
// Optional feature macro MAU_SUBWORD_EN enables byte/half accesses; the default build is word-only.
module mem_access_unit #(
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_writeenable,
    input  logic [31:0] mem_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [31:0] LIMIT     = 32'(ADDR_LIMIT);
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    state_t      state, state_next;
    logic        write_q, err_q;
    logic [31:0] addr_q, wdata_q, rd_buf;
    logic        accept, req_err;
    logic [31:0] store_word, load_word;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
`ifdef MAU_SUBWORD_EN
        req_err = (req_size == 2'b11)
               || (req_size == SIZE_HALF && req_addr[0])
               || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00);
`else
        req_err = (req_size != SIZE_WORD) || (req_addr[1:0] != 2'b00);
`endif
        if ({req_addr[31:2], 2'b00} >= LIMIT) req_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            err_q   <= req_err;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Memory read data is valid by the end of the RD cycle.
    always_ff @(posedge clk) begin
        if (reset)            rd_buf <= '0;
        else if (state == RD) rd_buf <= mem_data;
    end

`ifdef MAU_SUBWORD_EN
    logic [1:0]  size_q;
    logic        signed_q;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask, lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q   <= '0;
            signed_q <= 1'b0;
        end else if (accept) begin
            size_q   <= req_size;
            signed_q <= req_signed;
        end
    end

    // Big-endian lanes: byte k sits at bit 8*(3-k), half 0 at bit 16; a word covers all lanes.
    always_comb begin
        lane_shift = '0;
        lane_mask  = '1;
        case (size_q)
            2'b00:   begin
                lane_shift = {~addr_q[1:0], 3'b000};
                lane_mask  = 32'h0000_00FF << lane_shift;
            end
            2'b01:   begin
                lane_shift = {~addr_q[1], 4'b0000};
                lane_mask  = 32'h0000_FFFF << lane_shift;
            end
            default: ;
        endcase
        lane       = (rd_buf & lane_mask) >> lane_shift;
        store_word = (rd_buf & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
        case (size_q)
            2'b00:   load_word = signed_q ? {{24{lane[7]}}, lane[7:0]}   : lane;
            2'b01:   load_word = signed_q ? {{16{lane[15]}}, lane[15:0]} : lane;
            default: load_word = lane;
        endcase
    end
`else
    logic unused_bits;
    assign unused_bits = ^{req_signed, addr_q[1:0]};
    assign store_word  = wdata_q;
    assign load_word   = rd_buf;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next      = state;
        mem_address     = '0;
        mem_writedata   = '0;
        mem_writeenable = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_error      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                               state_next = RESP;
                    else if (req_write && req_size == SIZE_WORD) state_next = WR;
                    else                                       state_next = RD;
                end
            end
            RD: begin
                mem_address = {addr_q[31:2], 2'b00};
                state_next  = write_q ? WR : RESP;
            end
            WR: begin
                mem_address     = {addr_q[31:2], 2'b00};
                mem_writedata   = store_word;
                mem_writeenable = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                if (!err_q && !write_q) resp_rdata = load_word;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts responses and writes.
// Follows MAU_SUBWORD_EN the same way the design does.
module tb_mem_access_unit;

`ifdef MAU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif
    localparam int LIMIT = 1024;

    logic        clk, reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error, mem_writeenable;
    logic [31:0] resp_rdata, mem_address, mem_writedata, mem_data;

    mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_writeenable(mem_writeenable), .mem_data(mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural dataMem with a backdoor byte port for preloading.
    logic [7:0] mem [0:LIMIT-1];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr;
    logic [7:0] bd_data;

    always @(posedge clk) begin
        if (mem_writeenable) begin
            mem[{mem_address[9:2], 2'b00}] <= mem_writedata[31:24];
            mem[{mem_address[9:2], 2'b01}] <= mem_writedata[23:16];
            mem[{mem_address[9:2], 2'b10}] <= mem_writedata[15:8];
            mem[{mem_address[9:2], 2'b11}] <= mem_writedata[7:0];
        end
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    always_comb begin
        mem_data = '0;
        if (mem_address < LIMIT)
            mem_data = {mem[{mem_address[9:2], 2'b00}], mem[{mem_address[9:2], 2'b01}],
                        mem[{mem_address[9:2], 2'b10}], mem[{mem_address[9:2], 2'b11}]};
    end

    typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    resp_t      rq[$];
    wr_t        wq[$];
    logic [7:0] ref_mem [0:LIMIT-1];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain byte-array semantics of the request rules.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int c0);
        resp_t       r;
        wr_t         x;
        int          n, base, lat;
        logic        err;
        logic [31:0] v;
        n = 1 << sz;
        if (SUBWORD) err = (sz == 2'd3) || (a % n != 0);
        else         err = (sz != 2'd2) || (a % 4 != 0);
        if ((a & ~32'h3) >= LIMIT) err = 1'b1;
        r.rdata = '0;
        r.err   = err;
        if (err) begin
            lat = 1;
        end else begin
            base = int'(a & ~32'h3);
            if (!w) begin
                v = '0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
                if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                r.rdata = v;
                lat = 2;
            end else begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
                x.addr = 32'(base);
                x.data = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
                wq.push_back(x);
                lat = (n == 4) ? 2 : 3;
            end
        end
        r.cyc = c0 + lat;
        rq.push_back(r);
    endtask

    // Monitor: every write and every response must match the oldest expectation.
    always @(negedge clk) begin
        if (mem_writeenable) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(mem_writeenable), 32'd0);
            end else begin
                wr_t x;
                x = wq.pop_front();
                check("write_addr", mem_address, x.addr);
                check("write_data", mem_writedata, x.data);
            end
        end
        if (resp_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                resp_t r;
                r = rq.pop_front();
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_error", 32'(resp_error), 32'(r.err));
                check("resp_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic bd_write(input int a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 10'(a); bd_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Waits for ready at a negedge, drives the request, returns right after the accept edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit push);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        if (push) model(w, sz, sg, a, wd, cyc);
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_we", 32'(mem_writeenable), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_address", mem_address, 32'd0);
        check("rst_writedata", mem_writedata, 32'd0);

        for (int i = 0; i < 64; i++) bd_write(i, 8'($urandom));
        for (int i = LIMIT - 16; i < LIMIT; i++) bd_write(i, 8'($urandom));
        bd_write(16'h10, 8'h11); bd_write(16'h11, 8'h22);
        bd_write(16'h12, 8'h33); bd_write(16'h13, 8'h44);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        repeat (3) @(negedge clk);
        bd_write(16'h13, 8'hF4);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h1234_5678, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'(LIMIT), 32'h0, 1'b1);

        // Reset while the access sits in RD: no write, no response.
        if (SUBWORD) issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0055, 1'b0);
        else         issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", 32'(req_ready), 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);

        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0099, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 32'($urandom_range(0, 63));
            else if (sel < 9) a = 32'(LIMIT - 8 + $urandom_range(0, 15));
            else              a = $urandom;
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b1);
        end
        @(negedge clk);
        req_valid = 1'b0;

        for (int t = 0; t < 20 && (rq.size() != 0 || wq.size() != 0); t++) @(negedge clk);
        check("pending_responses", 32'(rq.size()), 32'd0);
        check("pending_writes", 32'(wq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
